// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS core.
// Steps the frequency word K from k_start by k_step every max(dwell,1) cycles
// for n_steps increments, optionally looping, with hold (freeze) and abort.
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          hold,
  input  logic          loop_en,
  input  logic          dir_down,
  input  logic [KW-1:0] k_start,
  input  logic [KW-1:0] k_step,
  input  logic [CW-1:0] n_steps,
  input  logic [CW-1:0] dwell,
  input  logic [PW-1:0] p_offset,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          busy,
  output logic          step_stb,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state_reg;

  // Sweep configuration captured at start; live inputs are ignored while busy.
  logic [KW-1:0] k_start_reg;
  logic [KW-1:0] k_step_reg;
  logic [CW-1:0] n_steps_reg;
  logic [CW-1:0] dwell_rld_reg;
  logic          loop_reg;
  logic          dir_reg;

  // Sweep progress and registered outputs.
  logic [KW-1:0] k_reg;
  logic [PW-1:0] p_reg;
  logic [CW-1:0] dwell_cnt_reg;
  logic [CW-1:0] idx_reg;
  logic          busy_reg;
  logic          stb_reg;
  logic          done_reg;

  // A dwell of 0 behaves like 1, so the reload value saturates at 0.
  logic [CW-1:0] dwell_rld_in;
  logic [KW-1:0] k_stepped;

  assign dwell_rld_in = (dwell == '0) ? '0 : dwell - 1'b1;
  // Modulo-2^KW step in either direction; wrap-around is intentional.
  assign k_stepped    = dir_reg ? (k_reg - k_step_reg) : (k_reg + k_step_reg);

  // Sweep state machine: start, dwell counting, stepping, loop/end, hold and abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      k_start_reg   <= '0;
      k_step_reg    <= '0;
      n_steps_reg   <= '0;
      dwell_rld_reg <= '0;
      loop_reg      <= 1'b0;
      dir_reg       <= 1'b0;
      k_reg         <= '0;
      p_reg         <= '0;
      dwell_cnt_reg <= '0;
      idx_reg       <= '0;
      busy_reg      <= 1'b0;
      stb_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Pulses default low; only the branches below raise them for one cycle.
      stb_reg  <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (abort) begin
            // Abort wins over a simultaneous start and clears the outputs.
            k_reg <= '0;
            p_reg <= '0;
          end else if (start) begin
            k_start_reg   <= k_start;
            k_step_reg    <= k_step;
            n_steps_reg   <= n_steps;
            dwell_rld_reg <= dwell_rld_in;
            loop_reg      <= loop_en;
            dir_reg       <= dir_down;
            k_reg         <= k_start;
            p_reg         <= p_offset;
            dwell_cnt_reg <= dwell_rld_in;
            idx_reg       <= '0;
            stb_reg       <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= ST_RUN;
          end
        end

        ST_RUN, ST_HOLD: begin
          if (abort) begin
            state_reg     <= ST_IDLE;
            k_reg         <= '0;
            p_reg         <= '0;
            busy_reg      <= 1'b0;
            dwell_cnt_reg <= '0;
            idx_reg       <= '0;
          end else if (hold) begin
            // Frozen: no counter or output moves, and the cycle is not counted.
            state_reg <= ST_HOLD;
          end else begin
            // Leaving HOLD resumes immediately, so the release edge counts.
            state_reg <= ST_RUN;
            if (dwell_cnt_reg != '0) begin
              dwell_cnt_reg <= dwell_cnt_reg - 1'b1;
            end else if (idx_reg < n_steps_reg) begin
              k_reg         <= k_stepped;
              idx_reg       <= idx_reg + 1'b1;
              dwell_cnt_reg <= dwell_rld_reg;
              stb_reg       <= 1'b1;
            end else if (loop_reg) begin
              k_reg         <= k_start_reg;
              idx_reg       <= '0;
              dwell_cnt_reg <= dwell_rld_reg;
              stb_reg       <= 1'b1;
            end else begin
              // Single sweep finished: K and P keep their last values.
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign K        = k_reg;
  assign P        = p_reg;
  assign busy     = busy_reg;
  assign step_stb = stb_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: each sweep's expected step/done pulses are
// computed in closed form and queued; a monitor pops and compares them as they appear.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, hold, loop_en, dir_down;
  logic [31:0] k_start, k_step;
  logic [15:0] n_steps, dwell;
  logic [10:0] p_offset;
  logic [31:0] K;
  logic [10:0] P;
  logic        busy, step_stb, done;

  dds_sweep_ctrl #(.KW(32), .PW(11), .CW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .loop_en(loop_en), .dir_down(dir_down), .k_start(k_start), .k_step(k_step),
    .n_steps(n_steps), .dwell(dwell), .p_offset(p_offset),
    .K(K), .P(P), .busy(busy), .step_stb(step_stb), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int unsigned cyc;
    logic [31:0] k;
    logic [10:0] p;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int unsigned busy_from = 0;
  int unsigned busy_to = 0;
  logic [31:0] exp_k_hold = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Expected frequency word number j of a sweep, from the closed form.
  function automatic logic [31:0] word_k(input logic [31:0] kst, input logic [31:0] kstp,
                                         input int n, input bit dn, input int j);
    logic [31:0] m;
    logic [31:0] off;
    m   = 32'(j % (n + 1));
    off = m * kstp;
    return dn ? (kst - off) : (kst + off);
  endfunction

  // Monitor: pops expected pulses and tracks the expected busy window and held K.
  ev_t mon_ev;
  bit  exp_busy;
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse: got nothing by cycle %0d, required pulse at cycle %0d",
                 cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      check("stb_done_exclusive", {63'd0, step_stb & done}, 64'd0);
      if (step_stb || done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse at cycle %0d: got stb=%0b done=%0b, required none",
                   cyc, step_stb, done);
        end else begin
          mon_ev = exp_q.pop_front();
          check("pulse_cycle", 64'(cyc), 64'(mon_ev.cyc));
          check("pulse_is_done", {63'd0, done}, {63'd0, mon_ev.is_done});
          check("pulse_K", 64'(K), 64'(mon_ev.k));
          check("pulse_P", 64'(P), 64'(mon_ev.p));
          if (!mon_ev.is_done) exp_k_hold = mon_ev.k;
        end
      end
      exp_busy = (cyc >= busy_from) && (cyc < busy_to);
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      if (exp_busy) check("K_held", 64'(K), 64'(exp_k_hold));
    end
  end

  // Plans one sweep (offsets are edges after the start edge e; 0 = unused), queues its
  // expected pulses, then drives it edge by edge, scrambling config inputs while busy.
  task automatic run_sweep(input logic [31:0] kst, input logic [31:0] kstp, input int n,
                           input int dw, input bit dn, input bit lp, input logic [10:0] pof,
                           input int hold_off, input int hold_len, input int abort_off,
                           input int rst_off, input bit poke);
    int          d;
    int unsigned e, h, t, kill, poke_edge, nx, x;
    logic [31:0] klast;
    ev_t         ev;
    d     = (dw == 0) ? 1 : dw;
    e     = cyc + 1;
    h     = (hold_len > 0) ? e + hold_off : 0;
    kill  = (abort_off > 0) ? e + abort_off : ((rst_off > 0) ? e + rst_off : 0);
    klast = kst;
    for (int j = 0; (j <= n || lp) && j < 1000; j++) begin
      t = e + j * d;
      if (hold_len > 0 && t >= h) t += hold_len;
      if (kill != 0 && t >= kill) break;
      ev.is_done = 1'b0; ev.cyc = t; ev.k = word_k(kst, kstp, n, dn, j); ev.p = pof;
      exp_q.push_back(ev);
      klast = ev.k;
    end
    if (!lp) begin
      t = e + (n + 1) * d;
      if (hold_len > 0 && t >= h) t += hold_len;
      if (kill == 0 || t < kill) begin
        ev.is_done = 1'b1; ev.cyc = t; ev.k = klast; ev.p = pof;
        exp_q.push_back(ev);
        busy_to = t;
      end else begin
        busy_to = kill;
      end
    end else begin
      busy_to = kill;
    end
    busy_from = e;
    poke_edge = (poke && busy_to > e + 1) ? e + $urandom_range(1, busy_to - e - 1) : 0;

    x = cyc;
    while (x <= busy_to + 2) begin
      nx    = x + 1;
      start = (nx == e) || (poke_edge != 0 && nx == poke_edge);
      hold  = (hold_len > 0) && (nx >= h) && (nx < h + hold_len);
      abort = (abort_off > 0) && (nx == kill);
      rst   = (rst_off > 0) && (nx == kill);
      if (nx == e) begin
        k_start = kst; k_step = kstp; n_steps = 16'(n); dwell = 16'(dw);
        dir_down = dn; loop_en = lp; p_offset = pof;
      end else if (nx > e) begin
        k_start = $urandom; k_step = $urandom; n_steps = 16'($urandom_range(0, 3));
        dwell = 16'($urandom_range(0, 3)); dir_down = 1'($urandom);
        loop_en = 1'($urandom); p_offset = 11'($urandom);
      end
      if (kill != 0 && x == kill) begin
        check("kill_K_zero", 64'(K), 64'd0);
        check("kill_P_zero", 64'(P), 64'd0);
        check("kill_no_stb", {63'd0, step_stb}, 64'd0);
        check("kill_no_done", {63'd0, done}, 64'd0);
      end
      if (!lp && kill == 0 && x == busy_to + 1) begin
        check("end_K_kept", 64'(K), 64'(klast));
        check("end_P_kept", 64'(P), 64'(pof));
      end
      @(negedge clk);
      x++;
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0; rst = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    $display("sweep kst=%0h step=%0h n=%0d dwell=%0d dn=%0b loop=%0b hold=%0d/%0d abort=%0d rst=%0d poke=%0b",
             kst, kstp, n, dw, dn, lp, hold_off, hold_len, abort_off, rst_off, poke);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, dw, d, len, hl, ho, ao, ro;
    bit lp;
    rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; loop_en = 1'b0; dir_down = 1'b0;
    k_start = '0; k_step = '0; n_steps = '0; dwell = '0; p_offset = '0;
    repeat (3) @(negedge clk);
    check("reset_K", 64'(K), 64'd0);
    check("reset_P", 64'(P), 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_stb", {63'd0, step_stb}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single up-sweep, then a start pulse landing mid-sweep.
    run_sweep(32'd1000, 32'd100, 3, 4, 1'b0, 1'b0, 11'h2A5, 0, 0, 0, 0, 1'b0);
    run_sweep(32'd1000, 32'd100, 3, 4, 1'b0, 1'b0, 11'h2A5, 0, 0, 0, 0, 1'b1);
    // start together with abort in IDLE: no sweep, K and P forced to 0.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_K", 64'(K), 64'd0);
    check("idle_abort_P", 64'(P), 64'd0);
    repeat (4) @(negedge clk);
    check("idle_abort_no_sweep", {63'd0, busy}, 64'd0);
    $display("start+abort in idle");
    // Down-sweep wrap with dwell 0.
    run_sweep(32'd50, 32'd100, 1, 0, 1'b1, 1'b0, 11'h011, 0, 0, 0, 0, 1'b0);
    // Looping sweep aborted mid-dwell.
    run_sweep(32'd10, 32'd5, 1, 2, 1'b0, 1'b1, 11'h123, 0, 0, 5, 0, 1'b0);
    // Hold for 5 cycles starting in the second cycle of a dwell.
    run_sweep(32'd7000, 32'd3, 2, 3, 1'b0, 1'b0, 11'h055, 2, 5, 0, 0, 1'b0);
    // Reset mid-sweep; the sweep must not resume.
    run_sweep(32'd400, 32'd20, 3, 2, 1'b0, 1'b0, 11'h3FF, 0, 0, 0, 3, 1'b0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      n   = $urandom_range(0, 4);
      dw  = $urandom_range(0, 4);
      d   = (dw == 0) ? 1 : dw;
      len = (n + 1) * d;
      lp  = ($urandom_range(0, 3) == 0);
      hl  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      ho  = (hl > 0) ? $urandom_range(1, len) : 0;
      ao  = 0;
      ro  = 0;
      if (lp || (len > 1 && $urandom_range(0, 3) == 0)) begin
        if (lp) begin
          if ($urandom_range(0, 1) == 1) ao = $urandom_range(1, 2 * len + 4);
          else ro = $urandom_range(1, 2 * len + 4);
        end else begin
          if ($urandom_range(0, 1) == 1) ao = $urandom_range(1, len - 1);
          else ro = $urandom_range(1, len - 1);
        end
      end
      run_sweep($urandom, $urandom, n, dw, 1'($urandom), lp, 11'($urandom),
                ho, hl, ao, ro, 1'($urandom));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 Parameters: KW, default 32, frequency-word width; PW, default 11, phase-offset width; CW, default 16, step-count and dwell-count width.
REQ-002 Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep immediately
- hold  in  1  freeze sweep progress while high
- loop_en  in  1  1 = restart sweep at end; 0 = single sweep
- dir_down  in  1  1 = subtract step; 0 = add step
- k_start  in  KW  first frequency word
- k_step  in  KW  frequency-word increment, unsigned
- n_steps  in  CW  number of increments after k_start
- dwell  in  CW  cycles per frequency word; 0 is treated as 1
- p_offset  in  PW  phase offset for the sweep
- K  out  KW  frequency word to the DDS accumulator
- P  out  PW  phase offset to the DDS
- busy  out  1  sweep active (RUN or HOLD)
- step_stb  out  1  one-cycle pulse, coincident with each new K value
- done  out  1  one-cycle pulse after a single sweep completes

Function
REQ-003 States are IDLE, RUN and HOLD. All outputs are registered.
REQ-004 IDLE with start=1 and abort=0: on the next edge, latch all config inputs, set K=k_start and P=p_offset, load dwell_cnt=max(dwell,1)-1, set idx=0, step_stb=1 and busy=1, and enter RUN.
REQ-005 Latched config is used for the whole sweep; input changes while busy=1 have no effect.
REQ-006 RUN with hold=0 and dwell_cnt>0: decrement dwell_cnt by 1.
REQ-007 RUN with hold=0, dwell_cnt=0 and idx<n_steps: K <= K+k_step (or K-k_step if dir_down), modulo 2^KW with wrap-around and no saturation; idx++; reload dwell_cnt; step_stb=1.
REQ-008 RUN with hold=0, dwell_cnt=0, idx=n_steps and loop_en latched=1: K <= k_start, idx=0, reload dwell_cnt, step_stb=1, and remain in RUN; done is not pulsed.
REQ-009 RUN with hold=0, dwell_cnt=0, idx=n_steps and loop_en latched=0: enter IDLE, busy=0, done=1 for one cycle; K and P hold their last values.
REQ-010 Each K value is held for exactly max(dwell,1) cycles while hold=0. A single sweep produces n_steps+1 words and lasts (n_steps+1)*max(dwell,1) cycles from the first step_stb to busy falling.
REQ-011 RUN with hold=1: enter HOLD. HOLD with hold=1: all state and outputs freeze. HOLD with hold=0: return to RUN and resume the count from where it stopped. Frozen cycles are not counted toward the dwell.
REQ-012 abort=1 in RUN or HOLD: on the next edge, enter IDLE with K=0, P=0 and busy=0; no done or step_stb pulse. Abort has priority over hold, step and end-of-sweep.
REQ-013 abort=1 in IDLE: K and P are forced to 0, and a simultaneous start is ignored.
REQ-014 start while busy=1 is ignored.
REQ-015 n_steps=0: the sweep emits only k_start for one dwell period, then completes or reloads.
REQ-016 step_stb and done never assert in the same cycle.

Reset
REQ-017 rst=1 at an edge: state=IDLE, K=0, P=0, busy=0, step_stb=0, done=0, and all counters cleared. rst has priority over every other input.
REQ-018 Reset mid-sweep behaves identically to reset from IDLE; the sweep does not resume after rst falls.

Verification
REQ-019 Single up-sweep, stimulus: k_start=1000, k_step=100, n_steps=3, dwell=4, loop_en=0. Required response:
- K sequence is 1000, 1100, 1200, 1300, each held 4 cycles.
- 4 step_stb pulses.
- busy high for 16 cycles.
- done pulses once, in the cycle busy falls.
REQ-020 Down-sweep wrap, stimulus: k_start=50, k_step=100, dir_down=1, n_steps=1, dwell=0. Required response: K=50 for 1 cycle, then K=0xFFFFFFCE (32-bit) for 1 cycle, then done.
REQ-021 Loop with abort, stimulus: k_start=10, k_step=5, n_steps=1, dwell=2, loop_en=1. Required response: K follows 10, 10, 15, 15, 10, ... with no done. Abort asserted mid-dwell gives K=0 and busy=0 on the next edge, with no done.
REQ-022 Hold, stimulus: dwell=3, with hold high for 5 cycles during the second cycle of a dwell. Required response: K is frozen for those 5 cycles, and that K value is held 3+5=8 cycles in total.
REQ-023 Edge cases, stimulus and required response:
- start while busy: no effect on the sweep in progress.
- start+abort in IDLE: no sweep starts.
- rst asserted mid-sweep: all outputs 0 next cycle, and the block stays IDLE after rst falls.
